// File: rtl/traffic_pkg.sv
// Shared types and lamp encodings for the traffic phase scheduler.
package traffic_pkg;

    typedef enum logic [2:0] {
        NS_G  = 3'd0,
        NS_Y  = 3'd1,
        ALL_R = 3'd2,
        EW_G  = 3'd3,
        EW_Y  = 3'd4,
        PED   = 3'd5
    } state_t;

    typedef enum logic {
        NS = 1'b0,
        EW = 1'b1
    } dir_t;

    localparam logic [2:0] LAMP_RED = 3'b100;
    localparam logic [2:0] LAMP_YEL = 3'b010;
    localparam logic [2:0] LAMP_GRN = 3'b001;

    // Returns {light_ns, light_ew} for a state.
    function automatic logic [5:0] lamps_of(input state_t s);
        logic [5:0] l;
        l = {LAMP_RED, LAMP_RED};
        case (s)
            NS_G:    l = {LAMP_GRN, LAMP_RED};
            NS_Y:    l = {LAMP_YEL, LAMP_RED};
            EW_G:    l = {LAMP_RED, LAMP_GRN};
            EW_Y:    l = {LAMP_RED, LAMP_YEL};
            default: l = {LAMP_RED, LAMP_RED};
        endcase
        return l;
    endfunction

endpackage

// File: rtl/traffic_phase_timer.sv
// Cycles-in-state counter: synchronous clear, saturates at MAX_COUNT-1.
module traffic_phase_timer #(
    parameter int unsigned MAX_COUNT = 20,
    parameter int unsigned W         = $clog2(MAX_COUNT)
) (
    input  logic         clk,
    input  logic         rst_a,
    input  logic         clear,
    output logic [W-1:0] count
);

    localparam logic [W-1:0] COUNT_LAST = W'(MAX_COUNT - 1);

    always_ff @(posedge clk or negedge rst_a) begin
        if (!rst_a) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (count != COUNT_LAST) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/traffic_phase_scheduler.sv
// Demand-driven two-way intersection phase scheduler with yellow/all-red clearance.
// Pedestrian phase is built only when TRAFFIC_PED_EN is defined.
module traffic_phase_scheduler
    import traffic_pkg::*;
#(
    parameter int unsigned GREEN_MIN = 8,
    parameter int unsigned GREEN_MAX = 20,
    parameter int unsigned YELLOW_T  = 3,
    parameter int unsigned ALLRED_T  = 2,
    parameter int unsigned PED_T     = 6
) (
    input  logic       clk,
    input  logic       rst_a,
    input  logic       car_ns,
    input  logic       car_ew,
    input  logic       ped_req,
    output logic [2:0] light_ns,
    output logic [2:0] light_ew,
    output logic       walk,
    output logic [2:0] phase
);

    localparam int unsigned TW = $clog2(GREEN_MAX);

    localparam logic [TW-1:0] T_GMIN = TW'(GREEN_MIN - 1);
    localparam logic [TW-1:0] T_GMAX = TW'(GREEN_MAX - 1);
    localparam logic [TW-1:0] T_YEL  = TW'(YELLOW_T - 1);
    localparam logic [TW-1:0] T_AR   = TW'(ALLRED_T - 1);

    state_t        state_q, state_d;
    dir_t          next_dir_q, next_dir_d;
    logic          ped_pending_q;
    logic [TW-1:0] timer;
    logic [5:0]    lamps_d;

    traffic_phase_timer #(
        .MAX_COUNT (GREEN_MAX),
        .W         (TW)
    ) u_timer (
        .clk   (clk),
        .rst_a (rst_a),
        .clear (state_d != state_q),
        .count (timer)
    );

    always_ff @(posedge clk or negedge rst_a) begin
        if (!rst_a) begin
            state_q    <= NS_G;
            next_dir_q <= EW;
            light_ns   <= LAMP_GRN;
            light_ew   <= LAMP_RED;
        end else begin
            state_q    <= state_d;
            next_dir_q <= next_dir_d;
            light_ns   <= lamps_d[5:3];
            light_ew   <= lamps_d[2:0];
        end
    end

    always_comb begin
        state_d    = state_q;
        next_dir_d = next_dir_q;
        case (state_q)
            NS_G: if (timer >= T_GMIN && (car_ew || ped_pending_q) &&
                      (!car_ns || timer == T_GMAX)) state_d = NS_Y;
            NS_Y: if (timer == T_YEL) begin
                state_d    = ALL_R;
                next_dir_d = EW;
            end
            EW_G: if (timer >= T_GMIN && (car_ns || ped_pending_q) &&
                      (!car_ew || timer == T_GMAX)) state_d = EW_Y;
            EW_Y: if (timer == T_YEL) begin
                state_d    = ALL_R;
                next_dir_d = NS;
            end
            ALL_R: if (timer == T_AR) begin
                if (ped_pending_q)           state_d = PED;
                else if (next_dir_q == NS)   state_d = NS_G;
                else                         state_d = EW_G;
            end
`ifdef TRAFFIC_PED_EN
            PED: if (timer == TW'(PED_T - 1)) begin
                state_d = (next_dir_q == NS) ? NS_G : EW_G;
            end
`endif
            default: state_d = NS_G;
        endcase
        lamps_d = lamps_of(state_d);
    end

    assign phase = state_q;

`ifdef TRAFFIC_PED_EN
    // A request arriving while it is being served (entry cycle or during PED) is absorbed.
    always_ff @(posedge clk or negedge rst_a) begin
        if (!rst_a) begin
            ped_pending_q <= 1'b0;
            walk          <= 1'b0;
        end else begin
            walk <= (state_d == PED);
            if (state_q == ALL_R && state_d == PED)
                ped_pending_q <= 1'b0;
            else if (ped_req && state_q != PED)
                ped_pending_q <= 1'b1;
        end
    end
`else
    logic ped_req_unused;
    assign ped_req_unused = ped_req;
    assign ped_pending_q  = 1'b0;
    assign walk           = 1'b0;
`endif

endmodule

// File: tb/tb_traffic_phase_scheduler.sv
// Directed self-checking bench for traffic_phase_scheduler (default parameters).
module tb_traffic_phase_scheduler;

    localparam logic [2:0] P_NSG = 3'd0;
    localparam logic [2:0] P_NSY = 3'd1;
    localparam logic [2:0] P_AR  = 3'd2;
    localparam logic [2:0] P_EWG = 3'd3;
    localparam logic [2:0] P_EWY = 3'd4;
    localparam logic [2:0] P_PED = 3'd5;

    logic       clk = 1'b0;
    logic       rst_a = 1'b0;
    logic       car_ns = 1'b0;
    logic       car_ew = 1'b0;
    logic       ped_req = 1'b0;
    logic [2:0] light_ns, light_ew, phase;
    logic       walk;

    int unsigned n_checks = 0;
    int unsigned n_fail = 0;

    always #5 clk = ~clk;

    traffic_phase_scheduler #(
        .GREEN_MIN (8),
        .GREEN_MAX (20),
        .YELLOW_T  (3),
        .ALLRED_T  (2),
        .PED_T     (6)
    ) dut (
        .clk      (clk),
        .rst_a    (rst_a),
        .car_ns   (car_ns),
        .car_ew   (car_ew),
        .ped_req  (ped_req),
        .light_ns (light_ns),
        .light_ew (light_ew),
        .walk     (walk),
        .phase    (phase)
    );

    // Expected {phase, light_ns, light_ew, walk} from the state table.
    function automatic logic [9:0] exp_vec(input logic [2:0] p);
        logic [2:0] ns, ew;
        ns = 3'b100;
        ew = 3'b100;
        if (p == P_NSG) ns = 3'b001;
        if (p == P_NSY) ns = 3'b010;
        if (p == P_EWG) ew = 3'b001;
        if (p == P_EWY) ew = 3'b010;
        return {p, ns, ew, (p == P_PED)};
    endfunction

    // Leaves the bench at a falling edge with reset just released: cycle 0.
    task automatic start_run();
        rst_a = 1'b0;
        repeat (2) @(negedge clk);
        rst_a = 1'b1;
    endtask

    task automatic test_reset();
        logic [9:0] exp;
        car_ns = 0; car_ew = 1; ped_req = 0;
        start_run();
        repeat (20) @(negedge clk);
        #3 rst_a = 1'b0;
        #1;
        exp = exp_vec(P_NSG);
        n_checks++;
        if ({phase, light_ns, light_ew, walk} !== exp) begin
            n_fail++;
            $display("FAIL reset_async: got %b expected %b", {phase, light_ns, light_ew, walk}, exp);
        end
        car_ew = 0;
        @(negedge clk);
        rst_a = 1'b1;
        for (int k = 0; k < 100; k++) begin
            n_checks++;
            if ({phase, light_ns, light_ew, walk} !== exp) begin
                n_fail++;
                $display("FAIL idle_dwell cycle %0d: got %b expected %b", k, {phase, light_ns, light_ew, walk}, exp);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_ew_demand();
        logic [2:0] p;
        car_ns = 0; car_ew = 1; ped_req = 0;
        start_run();
        for (int k = 0; k < 40; k++) begin
            p = (k < 8) ? P_NSG : (k < 11) ? P_NSY : (k < 13) ? P_AR : P_EWG;
            n_checks++;
            if ({phase, light_ns, light_ew, walk} !== exp_vec(p)) begin
                n_fail++;
                $display("FAIL ew_demand cycle %0d: got %b expected %b", k, {phase, light_ns, light_ew, walk}, exp_vec(p));
            end
            @(negedge clk);
        end
    endtask

    task automatic test_both_demand();
        logic [2:0] p;
        int m;
        car_ns = 1; car_ew = 1; ped_req = 0;
        start_run();
        for (int k = 0; k < 120; k++) begin
            m = k % 50;
            p = (m < 20) ? P_NSG : (m < 23) ? P_NSY : (m < 25) ? P_AR :
                (m < 45) ? P_EWG : (m < 48) ? P_EWY : P_AR;
            n_checks++;
            if ({phase, light_ns, light_ew, walk} !== exp_vec(p)) begin
                n_fail++;
                $display("FAIL both_demand cycle %0d: got %b expected %b", k, {phase, light_ns, light_ew, walk}, exp_vec(p));
            end
            @(negedge clk);
        end
        car_ns = 0; car_ew = 0;
    endtask

`ifdef TRAFFIC_PED_EN
    task automatic test_ped();
        logic [2:0] p;
        car_ns = 0; car_ew = 0; ped_req = 0;
        start_run();
        for (int k = 0; k < 45; k++) begin
            ped_req = (k == 2 || k == 15);
            p = (k < 8) ? P_NSG : (k < 11) ? P_NSY : (k < 13) ? P_AR :
                (k < 19) ? P_PED : P_EWG;
            n_checks++;
            if ({phase, light_ns, light_ew, walk} !== exp_vec(p)) begin
                n_fail++;
                $display("FAIL ped_phase cycle %0d: got %b expected %b", k, {phase, light_ns, light_ew, walk}, exp_vec(p));
            end
            @(negedge clk);
        end
        ped_req = 0;
    endtask
`else
    task automatic test_ped_disabled();
        car_ns = 0; car_ew = 0; ped_req = 0;
        start_run();
        for (int k = 0; k < 40; k++) begin
            ped_req = (k == 2 || k == 5 || k == 15);
            n_checks++;
            if ({phase, light_ns, light_ew, walk} !== exp_vec(P_NSG)) begin
                n_fail++;
                $display("FAIL ped_disabled cycle %0d: got %b expected %b", k, {phase, light_ns, light_ew, walk}, exp_vec(P_NSG));
            end
            @(negedge clk);
        end
        ped_req = 0;
    endtask
`endif

    task automatic test_reset_mid_yellow();
        logic [2:0] p;
        car_ns = 0; ped_req = 0;
`ifdef TRAFFIC_PED_EN
        car_ew = 0;
`else
        car_ew = 1;
`endif
        start_run();
        for (int k = 0; k < 10; k++) begin
`ifdef TRAFFIC_PED_EN
            ped_req = (k == 2);
`endif
            p = (k < 8) ? P_NSG : P_NSY;
            n_checks++;
            if ({phase, light_ns, light_ew, walk} !== exp_vec(p)) begin
                n_fail++;
                $display("FAIL pre_reset cycle %0d: got %b expected %b", k, {phase, light_ns, light_ew, walk}, exp_vec(p));
            end
            @(negedge clk);
        end
        car_ew = 0; ped_req = 0;
        #3 rst_a = 1'b0;
        #1;
        n_checks++;
        if ({phase, light_ns, light_ew, walk} !== exp_vec(P_NSG)) begin
            n_fail++;
            $display("FAIL reset_in_yellow: got %b expected %b", {phase, light_ns, light_ew, walk}, exp_vec(P_NSG));
        end
        @(negedge clk);
        rst_a = 1'b1;
        for (int k = 0; k < 40; k++) begin
            n_checks++;
            if ({phase, light_ns, light_ew, walk} !== exp_vec(P_NSG)) begin
                n_fail++;
                $display("FAIL post_reset cycle %0d: got %b expected %b", k, {phase, light_ns, light_ew, walk}, exp_vec(P_NSG));
            end
            @(negedge clk);
        end
    endtask

    initial begin
        test_reset();
        test_ew_demand();
        test_both_demand();
`ifdef TRAFFIC_PED_EN
        test_ped();
`else
        test_ped_disabled();
`endif
        test_reset_mid_yellow();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
